// File: rtl/audio_pkg.sv
// Shared audio constants and the stereo frame layout for the I2S transmit path.
// Latency: none, types and constants only.
// Backpressure: none, carries no flow control of its own.
package audio_pkg;

  localparam int AUDIO_SAMPLE_W = 16;
  localparam int AUDIO_SLOT_W   = 32;

  // LRCLK level that identifies each channel slot
  localparam logic AUDIO_CH_LEFT  = 1'b0;
  localparam logic AUDIO_CH_RIGHT = 1'b1;

  // One stereo frame as carried on the sample stream, left in the upper half
  typedef struct packed {
    logic [AUDIO_SAMPLE_W-1:0] left;
    logic [AUDIO_SAMPLE_W-1:0] right;
  } stereo_frame_t;

endpackage

// File: rtl/audio_sample_fifo.sv
// Synchronous FIFO of stereo frames with occupancy count; head word is read straight from storage registers.
// Latency: a pushed word is visible at the head one cycle after the push; no same-cycle bypass.
// Backpressure: full blocks pushes; pop on empty is ignored, so a pop into an empty FIFO is the caller's underrun.
module audio_sample_fifo #(
  parameter int  WIDTH = 32,
  parameter int  DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  // Empty/full come from the registered level, so a push this cycle cannot feed a pop this cycle
  assign empty     = (level == '0);
  assign full      = (level == (AW+1)'(DEPTH));
  assign do_push   = push & ~full;
  assign do_pop    = pop & ~empty;
  assign head_data = mem_q[rd_ptr_q];

  // Storage array: written only on an accepted push, contents need no reset
  always_ff @(posedge Clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; level tracks push minus pop
  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/i2s_tx_stream.sv
// I2S transmit engine: MCLK divider, SCLK/LRCLK slave synchronisers, slot control and DOUT shift register.
// Latency: DOUT follows a pin SCLK fall by about SYNC_STAGES+2 Clk cycles; the MSB leads one SCLK after each LRCLK edge.
// Backpressure: s_ready drops while the frame FIFO is full; an empty FIFO at a left slot sends zeros and flags underrun.
module i2s_tx_stream
  import audio_pkg::*;
#(
  parameter int SAMPLE_W      = AUDIO_SAMPLE_W,
  parameter int SLOT_W        = AUDIO_SLOT_W,
  parameter int FIFO_DEPTH    = 16,
  parameter int MCLK_DIV_LOG2 = 2,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic [2*SAMPLE_W-1:0]         s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic                          mono_en,
  input  logic                          mute,
  input  logic                          underrun_clr,
  output logic                          MCLK,
  input  logic                          SCLK,
  input  logic                          LRCLK,
  output logic                          DOUT,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underrun,
  output logic                          frame_tick
);

  // Zero bits appended after the sample to fill the slot
  localparam int PAD_W = SLOT_W - SAMPLE_W;

  logic [MCLK_DIV_LOG2-1:0] mclk_cnt_q;
  logic [SYNC_STAGES-1:0]   sclk_sync_q;
  logic [SYNC_STAGES-1:0]   lrclk_sync_q;
  logic                     sclk_d_q;
  logic                     sclk_s;
  logic                     lrclk_s;
  logic                     sclk_rise;
  logic                     sclk_fall;

  logic                     lr_now_q;
  logic                     lr_prev_q;
  logic                     armed_q;
  logic [SAMPLE_W-1:0]      held_left_q;
  logic [SAMPLE_W-1:0]      held_right_q;
  logic [SLOT_W-1:0]        shreg_q;

  logic                     slot_start;
  logic                     left_start;
  logic                     right_start;
  logic                     underrun_set;
  logic [SAMPLE_W-1:0]      load_val;

  logic [2*SAMPLE_W-1:0]    fifo_head;
  logic [SAMPLE_W-1:0]      head_left;
  logic [SAMPLE_W-1:0]      head_right;
  logic                     fifo_empty;
  logic                     fifo_full;

  // Free-running MCLK divider, independent of the codec clocks
  always_ff @(posedge Clk) begin
    if (Reset) begin
      mclk_cnt_q <= '0;
    end else begin
      mclk_cnt_q <= mclk_cnt_q + 1'b1;
    end
  end

  assign MCLK = mclk_cnt_q[MCLK_DIV_LOG2-1];

  // Bring SCLK and LRCLK into the Clk domain through matched-depth chains and keep SCLK history for edges
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sclk_sync_q  <= '0;
      lrclk_sync_q <= '0;
      sclk_d_q     <= 1'b0;
    end else begin
      sclk_sync_q  <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
      lrclk_sync_q <= {lrclk_sync_q[SYNC_STAGES-2:0], LRCLK};
      sclk_d_q     <= sclk_s;
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign lrclk_s   = lrclk_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d_q;
  assign sclk_fall = ~sclk_s & sclk_d_q;

  // A slot starts on the SCLK fall after LRCLK was seen to change, giving the one-bit I2S delay
  assign slot_start   = sclk_fall & (lr_now_q != lr_prev_q);
  assign left_start   = slot_start & (lr_now_q == AUDIO_CH_LEFT);
  assign right_start  = slot_start & (lr_now_q == AUDIO_CH_RIGHT);
  assign underrun_set = left_start & fifo_empty;

  assign head_left  = fifo_head[2*SAMPLE_W-1:SAMPLE_W];
  assign head_right = fifo_head[SAMPLE_W-1:0];

  audio_sample_fifo #(
    .WIDTH (2*SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .Clk       (Clk),
    .Reset     (Reset),
    .push      (s_valid),
    .push_data (s_data),
    .pop       (left_start),
    .head_data (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .level     (fifo_level)
  );

  assign s_ready = ~fifo_full;

  // Pick the sample for a slot load; right slots stay silent until a left slot has armed the stream
  always_comb begin
    load_val = '0;
    if (!mute) begin
      if (left_start && !fifo_empty) begin
        load_val = head_left;
      end else if (right_start && armed_q) begin
        load_val = mono_en ? held_left_q : held_right_q;
      end
    end
  end

  // Slot control: track LRCLK, load or shift the serialiser, hold the frame's samples for the right slot
  always_ff @(posedge Clk) begin
    if (Reset) begin
      lr_now_q     <= 1'b0;
      lr_prev_q    <= 1'b0;
      armed_q      <= 1'b0;
      held_left_q  <= '0;
      held_right_q <= '0;
      shreg_q      <= '0;
      frame_tick   <= 1'b0;
    end else begin
      frame_tick <= 1'b0;
      if (sclk_rise) begin
        lr_now_q <= lrclk_s;
      end
      if (sclk_fall) begin
        lr_prev_q <= lr_now_q;
        if (slot_start) begin
          shreg_q <= SLOT_W'(load_val) << PAD_W;
        end else begin
          shreg_q <= {shreg_q[SLOT_W-2:0], 1'b0};
        end
      end
      if (left_start) begin
        armed_q    <= 1'b1;
        frame_tick <= 1'b1;
        if (fifo_empty) begin
          held_left_q  <= '0;
          held_right_q <= '0;
        end else begin
          held_left_q  <= head_left;
          held_right_q <= head_right;
        end
      end
    end
  end

  // Sticky underrun flag; a new underrun outranks a clear in the same cycle
  always_ff @(posedge Clk) begin
    if (Reset) begin
      underrun <= 1'b0;
    end else if (underrun_set) begin
      underrun <= 1'b1;
    end else if (underrun_clr) begin
      underrun <= 1'b0;
    end
  end

  assign DOUT = shreg_q[SLOT_W-1];

endmodule
